// File: rtl/multicycle_controller.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/
// writeback, evaluates condition codes and paces the FPU.
module multicycle_controller #(
  parameter int FPU_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] FPUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FPUControl,
  output logic       ResSrc,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_EXECF, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(FPU_LAT - 1);

  state_t     state_q, state_d, tgt;
  logic [3:0] flags_q, flags_d;
  logic [3:0] cnt_q, cnt_d;
  logic       condex_q, condex_d;
  logic       cond_ok;
  logic [1:0] aluctl_dec;
  logic       rd15;

  logic       pcwrite_q, pcwrite_d;
  logic       adrsrc_q, adrsrc_d;
  logic       irwrite_q, irwrite_d;
  logic       memwrite_q, memwrite_d;
  logic       regwrite_q, regwrite_d;
  logic       alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] resultsrc_q, resultsrc_d;
  logic [1:0] aluctl_q, aluctl_d;
  logic       ressrc_q, ressrc_d;
  logic       done_q, done_d;

  assign rd15 = (Rd == 4'hF);

  // Condition evaluation against the stored NZCV flags
  always_comb begin
    cond_ok = 1'b0;
    unique case (Cond)
      4'h0: cond_ok = flags_q[2];
      4'h1: cond_ok = !flags_q[2];
      4'h2: cond_ok = flags_q[1];
      4'h3: cond_ok = !flags_q[1];
      4'h4: cond_ok = flags_q[3];
      4'h5: cond_ok = !flags_q[3];
      4'h6: cond_ok = flags_q[0];
      4'h7: cond_ok = !flags_q[0];
      4'h8: cond_ok = flags_q[1] & !flags_q[2];
      4'h9: cond_ok = !flags_q[1] | flags_q[2];
      4'hA: cond_ok = (flags_q[3] == flags_q[0]);
      4'hB: cond_ok = (flags_q[3] != flags_q[0]);
      4'hC: cond_ok = !flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
    endcase
  end

  // Data-processing command to ALU operation; unknown commands add
  always_comb begin
    aluctl_dec = 2'b00;
    unique case (Funct[4:1])
      4'b0100: aluctl_dec = 2'b00;
      4'b0010: aluctl_dec = 2'b01;
      4'b0000: aluctl_dec = 2'b10;
      4'b1100: aluctl_dec = 2'b11;
      default: aluctl_dec = 2'b00;
    endcase
  end

  // Next state, FPU wait counter, condition latch and flag updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    condex_d = condex_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        condex_d = cond_ok;
        unique case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          2'b11:   state_d = S_EXECF;
          default: state_d = Funct[5] ? S_EXECI : S_EXECR;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        if (Funct[0] && condex_q)
          flags_d = aluctl_dec[1]
                  ? {ALUFlags[3:2], flags_q[1:0]}
                  : ALUFlags;
      end
      S_EXECF: begin
        if (cnt_q == LAT_M1) begin
          state_d = S_ALUWB;
          cnt_d   = 4'd0;
          if (Funct[0] && condex_q)
            flags_d = FPUFlags;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode for the state being entered, so outputs register
  // in step with the state; reset steers everything to FETCH
  always_comb begin
    tgt         = reset ? S_FETCH : state_d;
    pcwrite_d   = 1'b0;
    adrsrc_d    = 1'b0;
    irwrite_d   = 1'b0;
    memwrite_d  = 1'b0;
    regwrite_d  = 1'b0;
    alusrca_d   = 1'b0;
    alusrcb_d   = 2'b00;
    resultsrc_d = 2'b00;
    aluctl_d    = 2'b00;
    ressrc_d    = 1'b1;
    done_d      = 1'b0;
    unique case (tgt)
      S_FETCH: begin
        irwrite_d   = 1'b1;
        alusrca_d   = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
        pcwrite_d   = 1'b1;
      end
      S_DECODE: begin
        alusrca_d   = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
      end
      S_MEMADR: alusrcb_d = 2'b01;
      S_MEMRD:  adrsrc_d  = 1'b1;
      S_MEMWB: begin
        resultsrc_d = 2'b01;
        regwrite_d  = condex_d;
        pcwrite_d   = condex_d & rd15;
        done_d      = 1'b1;
      end
      S_MEMWR: begin
        adrsrc_d   = 1'b1;
        memwrite_d = condex_d;
        done_d     = 1'b1;
      end
      S_EXECR:  aluctl_d = aluctl_dec;
      S_EXECI: begin
        alusrcb_d = 2'b01;
        aluctl_d  = aluctl_dec;
      end
      S_EXECF:  ressrc_d = 1'b0;
      S_ALUWB: begin
        regwrite_d = condex_d;
        pcwrite_d  = condex_d & rd15;
        ressrc_d   = (state_q != S_EXECF);
        done_d     = 1'b1;
      end
      S_BRANCH: begin
        alusrcb_d   = 2'b01;
        resultsrc_d = 2'b10;
        pcwrite_d   = condex_d;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // State, flags, counter, condition latch and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      cnt_q    <= 4'd0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      condex_q <= condex_d;
    end
    pcwrite_q   <= pcwrite_d;
    adrsrc_q    <= adrsrc_d;
    irwrite_q   <= irwrite_d;
    memwrite_q  <= memwrite_d;
    regwrite_q  <= regwrite_d;
    alusrca_q   <= alusrca_d;
    alusrcb_q   <= alusrcb_d;
    resultsrc_q <= resultsrc_d;
    aluctl_q    <= aluctl_d;
    ressrc_q    <= ressrc_d;
    done_q      <= done_d;
  end

  // Write enables are blocked for the whole cycle reset is high
  assign PCWrite    = pcwrite_q & ~reset;
  assign IRWrite    = irwrite_q & ~reset;
  assign MemWrite   = memwrite_q & ~reset;
  assign RegWrite   = regwrite_q & ~reset;
  assign AdrSrc     = adrsrc_q;
  assign ALUSrcA    = alusrca_q;
  assign ALUSrcB    = alusrcb_q;
  assign ResultSrc  = resultsrc_q;
  assign ALUControl = aluctl_q;
  assign ResSrc     = ressrc_q;
  assign InstrDone  = done_q;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign FPUControl = Funct[2:1];

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions
// checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

  localparam int LAT = 3;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5;
  localparam int XR = 6, XI = 7, XF = 8, WB = 9, BR = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags, FPUFlags;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FPUControl;
  logic       ResSrc, InstrDone;
  logic [19:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mflags;
  string nm [11] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB",
                     "MEMWR", "EXECR", "EXECI", "EXECF", "ALUWB",
                     "BRANCH"};

  multicycle_controller #(.FPU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .Cond(Cond), .ALUFlags(ALUFlags), .FPUFlags(FPUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .FPUControl(FPUControl),
    .ResSrc(ResSrc), .InstrDone(InstrDone)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc,
                FPUControl, ResSrc, InstrDone};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] c,
                                      input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_op(input logic [5:0] fn);
    case (fn[4:1])
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [19:0] expect_out(
      input int st, input logic [1:0] op, input logic [5:0] fn,
      input logic [3:0] rd, input logic cx);
    logic pcw, adr, irw, mw, rw, sa, rs, dn;
    logic [1:0] sb, res, ac;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; sa = 0; rs = 1; dn = 0;
    sb = 2'd0; res = 2'd0; ac = 2'd0;
    case (st)
      FE: begin irw = 1; sa = 1; sb = 2'd2; res = 2'd2; pcw = 1; end
      DE: begin sa = 1; sb = 2'd2; res = 2'd2; end
      MA: sb = 2'd1;
      MR: adr = 1;
      MB: begin res = 2'd1; rw = cx; pcw = cx && rd == 4'hF; dn = 1; end
      MW: begin adr = 1; mw = cx; dn = 1; end
      XR: ac = alu_op(fn);
      XI: begin sb = 2'd1; ac = alu_op(fn); end
      XF: rs = 0;
      WB: begin
        rw = cx; pcw = cx && rd == 4'hF; rs = (op != 2'd3); dn = 1;
      end
      BR: begin sb = 2'd1; res = 2'd2; pcw = cx; dn = 1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, sa, sb, res, ac, op,
            op == 2'd1, op == 2'd2, fn[2:1], rs, dn};
  endfunction

  // Entered at posedge+1 of a FETCH cycle
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] af, input logic [3:0] ff,
                           input logic rst_mw);
    int seq[$];
    logic cx;
    logic aborted;
    Op = op; Funct = fn; Rd = rd; Cond = cond;
    ALUFlags = af; FPUFlags = ff;
    cx = cond_holds(cond, mflags);
    aborted = 1'b0;
    seq.push_back(FE);
    seq.push_back(DE);
    case (op)
      2'd0: begin seq.push_back(fn[5] ? XI : XR); seq.push_back(WB); end
      2'd1: begin
        seq.push_back(MA);
        if (fn[0]) begin seq.push_back(MR); seq.push_back(MB); end
        else seq.push_back(MW);
      end
      2'd2: seq.push_back(BR);
      default: begin
        for (int k = 0; k < LAT; k++) seq.push_back(XF);
        seq.push_back(WB);
      end
    endcase
    foreach (seq[i]) begin
      if (!aborted) begin
        if (rst_mw && seq[i] == MW) begin
          reset = 1'b1;
          @(negedge clk);
          chk("rst_we", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'h0);
          @(posedge clk); #1;
          reset = 1'b0;
          mflags = 4'h0;
          chk("rst_flags", dut.flags_q, mflags);
          aborted = 1'b1;
        end else begin
          @(negedge clk);
          chk($sformatf("%s op%0d fn%b c%h", nm[seq[i]], op, fn, cond),
              obs, expect_out(seq[i], op, fn, rd, cx));
          @(posedge clk); #1;
        end
      end
    end
    if (!aborted) begin
      if (fn[0] && cx) begin
        if (op == 2'd0)
          mflags = alu_op(fn) >= 2'd2 ? {af[3:2], mflags[1:0]} : af;
        else if (op == 2'd3)
          mflags = ff;
      end
      chk("flags", dut.flags_q, mflags);
    end
  endtask

  initial begin
    reset = 1'b1;
    Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Cond = 4'hE;
    ALUFlags = 4'd0; FPUFlags = 4'd0;
    mflags = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_we", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_flags", dut.flags_q, 4'h0);

    run_instr(2'd0, 6'b101001, 4'd1, 4'hE, 4'b0110, 4'd0, 1'b0);
    run_instr(2'd2, 6'b000000, 4'd0, 4'h1, 4'd0, 4'd0, 1'b0);
    run_instr(2'd2, 6'b000000, 4'd0, 4'h0, 4'd0, 4'd0, 1'b0);
    run_instr(2'd1, 6'b000001, 4'd15, 4'hE, 4'd0, 4'd0, 1'b0);
    run_instr(2'd3, 6'b000101, 4'd3, 4'hE, 4'd0, 4'b1000, 1'b0);
    run_instr(2'd0, 6'b001001, 4'd2, 4'hE, 4'b0011, 4'd0, 1'b0);
    run_instr(2'd0, 6'b000001, 4'd2, 4'hE, 4'b0100, 4'd0, 1'b0);
    run_instr(2'd1, 6'b000000, 4'd2, 4'hE, 4'd0, 4'd0, 1'b1);
    run_instr(2'd2, 6'b000000, 4'd0, 4'h0, 4'd0, 4'd0, 1'b0);
    run_instr(2'd0, 6'b011000, 4'd15, 4'hF, 4'hF, 4'd0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle build of the integer/floating-point processor. It decodes the latched instruction fields and sequences the shared ALU, FPU, register file, memory port and PC through fetch, decode, execute, memory and writeback steps. It evaluates condition codes against an internal NZCV flag register and holds the FPU operands for a configurable number of cycles. It drives all datapath selects and write enables; the datapath holds the IR, ALUOut, Data and PC registers.

## Interface
- FPU_LAT, 2: cycles the FPU needs to produce a valid result; legal range 1..15.

- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 FP op.
- Funct  input  6  Instr[25:20]: [5] I bit, [4:1] cmd (DP) / [2:1] fpu op (FP), [0] S bit (DP/FP) or L bit (memory).
- Rd  input  4  Instr[15:12].
- Cond  input  4  Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU.
- FPUFlags  input  4  {N,Z,C,V} from the FPU.
- PCWrite  output  1  PC register load enable.
- AdrSrc  output  1  0 = PC to memory address, 1 = ALUOut.
- IRWrite  output  1  IR load enable.
- MemWrite  output  1  data store enable.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = register rd1, 1 = PC.
- ALUSrcB  output  2  00 = rd2, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data register, 10 = OPResult direct.
- ImmSrc  output  2  equals Op (00 DP imm8, 01 mem imm12, 10 branch imm24).
- RegSrc  output  2  [0] = (Op==10), [1] = (Op==01).
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FPUControl  output  2  Funct[2:1].
- ResSrc  output  1  1 = ALU result to OPResult, 0 = FPU result.
- InstrDone  output  1  one-cycle pulse in the last state of every instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, EXECF, ALUWB, BRANCH.
- All outputs default to 0, except ResSrc, which defaults to 1. ImmSrc, RegSrc and FPUControl are combinational from Op/Funct in every state.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latch condex_q = CondEx(Cond, flags).
  - Next state: Op 01 goes to MEMADR; 10 to BRANCH; 11 to EXECF; 00 to EXECI if Funct[5], else EXECR.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state is MEMRD if Funct[0], else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=condex_q, InstrDone. Next state is FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=condex_q, InstrDone. Next state is FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 / 01, ALUControl from cmd. Next state is ALUWB.
  - cmd 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR; any other cmd → ADD.
- EXECF: ALUSrcA=0, ALUSrcB=00, ResSrc=0. A 4-bit counter starts at 0 and increments each cycle.
  - Remain in EXECF while cnt != FPU_LAT-1; then go to ALUWB and clear cnt.
- ALUWB: ResultSrc=00, RegWrite=condex_q, ResSrc = (previous state != EXECF), InstrDone. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=condex_q, InstrDone. Next state is FETCH.
- Writeback of Rd=15 in MEMWB/ALUWB additionally asserts PCWrite=condex_q.
- Flags register (4 bits) loads on the final cycle of EXECR/EXECI/EXECF when Funct[0] and condex_q are both set.
  - DP ADD/SUB: load all four from ALUFlags.
  - DP AND/ORR: load N,Z only; C,V are kept.
  - FP: load all four from FPUFlags.
- CondEx, with flags {N,Z,C,V}:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) = 1; 1111 = 0.

## Timing
- Reset (synchronous): state=FETCH, flags=0000, cnt=0, condex_q=0.
- While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. The first fetch occurs in the first cycle after reset is released.
- Reset asserted mid-instruction aborts it on the next edge; no write enable asserts in that reset cycle.
- Latency in cycles (FETCH to last state inclusive):
  - DP: 4. LDR: 5. STR: 4. B: 3. FP: 3+FPU_LAT.
- The DECODE-latched condex_q covers the whole instruction. A flag update in this instruction affects only the next instruction's DECODE.
- A failed condition still walks every state; only RegWrite, MemWrite and branch/R15 PCWrite are suppressed, and flags are held.

## Test plan
- Cond=1110, Op=00, Funct=101001 (ADDS imm) with ALUFlags=0110: state sequence FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in ALUWB; flags=0110 afterwards; one InstrDone pulse.
- Flags Z=1 set, then Cond=0001 (NE) branch: BRANCH is visited with PCWrite=0. Repeat with Cond=0000: PCWrite=1.
- LDR (Op=01, Funct[0]=1, Rd=15): 5 cycles; in MEMWB, RegWrite=1, PCWrite=1 and ResultSrc=01.
- FP op with FPU_LAT=3, Funct=000101: EXECF held 3 cycles with ResSrc=0 and FPUControl=10; ALUWB has ResSrc=0; flags take FPUFlags=1000.
- AND with S (cmd 0000, S=1) from flags 0011 and ALUFlags=0100: flags become 0111 (C,V kept).
- Reset pulsed in MEMWR with Cond=AL: MemWrite stays 0 in that cycle, and the next cycle is FETCH with flags=0000.
